move_cmd_gen: RTL

- Input-side producer of move commands for the 2048 game controller.
- Synchronizes and debounces the five board push-buttons: Up, Down, Left, Right, and Centre (start/restart).
- Issues exactly one direction command per physical press over a req/ack handshake.
- Emits a one-cycle start pulse for the game controller's init/restart path.

---
 rtl/move_cmd_gen.sv | 117 +++++++++++
 1 files changed

// File: rtl/move_cmd_gen.sv
// Debounces the five board buttons and issues one move command per press over req/ack, plus a start pulse.
// Latency: raw edge to move_req is DEBOUNCE_CYCLES+3 clocks. move_req/move_dir hold until move_ack; presses arriving while busy are dropped.
module move_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnC,
  input  logic       move_ack,
  output logic       move_req,
  output logic [1:0] move_dir,
  output logic       start_pulse,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  // Bit order everywhere: 0=Up 1=Down 2=Left 3=Right 4=Centre
  logic [4:0]       btn_raw;
  logic [4:0]       sync_a;
  logic [4:0]       sync_s;
  logic [4:0]       db;
  logic [4:0]       db_q;
  logic [4:0]       ev;
  logic [CNT_W-1:0] cnt [5];

  state_t     state;
  state_t     state_d;
  logic       req_d;
  logic [1:0] dir_d;

  assign btn_raw = {BtnC, BtnR, BtnL, BtnD, BtnU};
  assign ev      = db & ~db_q;
  assign busy    = (state == REQ) || (state == RELEASE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_a <= '0;
      sync_s <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_s <= sync_a;
    end
  end

  // A level must disagree for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      db_q <= db;
      for (int i = 0; i < 5; i++) begin
        if (sync_s[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db[i]  <= sync_s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state;
    req_d   = move_req;
    dir_d   = move_dir;
    case (state)
      IDLE: begin
        if (ev[4]) begin
          state_d = RELEASE;
        end else if (|ev[3:0]) begin
          state_d = REQ;
          req_d   = 1'b1;
          if (ev[0])      dir_d = 2'b00;
          else if (ev[1]) dir_d = 2'b01;
          else if (ev[2]) dir_d = 2'b10;
          else            dir_d = 2'b11;
        end
      end
      REQ: begin
        // Centre aborts the pending command regardless of a simultaneous ack.
        if (ev[4] || move_ack) begin
          state_d = RELEASE;
          req_d   = 1'b0;
        end
      end
      RELEASE: begin
        if (db[3:0] == 4'b0000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      move_req    <= 1'b0;
      move_dir    <= 2'b00;
      start_pulse <= 1'b0;
    end else begin
      state       <= state_d;
      move_req    <= req_d;
      move_dir    <= dir_d;
      start_pulse <= ev[4];
    end
  end

endmodule
